// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - frame-level receive controller: start/length/payload/checksum framing
//
// Sequences bytes from the serial receiver into frames of the form
// START_BYTE, length, payload[length], checksum (XOR of length and payload).
// A verified payload is held in an internal buffer until the consumer acks it.
//
// Ports:
//   clock, reset        system clock (rising edge), asynchronous active-high reset
//   rx_pronto, rx_dado  one-cycle byte-complete pulse and its byte
//   rx_erro             receiver parity-error pulse (same cycle as rx_pronto or the one before)
//   rd_addr, rd_data    combinational payload read port
//   frame_ack           consumer releases the held frame
//   frame_valid         a verified frame is held
//   frame_len           payload length of the held frame
//   frame_overrun       sticky: a byte arrived while a frame was held
//   erro, err_code      one-cycle error pulse and cause of the last error
//   db_estado           debug view of the FSM state
module rx_frame_ctrl #(
   parameter int         MAX_LEN    = 16,
   parameter int         TIMEOUT    = 50000,
   parameter logic [7:0] START_BYTE = 8'h23
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       rx_pronto,
   input  logic                       rx_erro,
   input  logic [7:0]                 rx_dado,
   input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
   input  logic                       frame_ack,
   output logic [7:0]                 rd_data,
   output logic                       frame_valid,
   output logic [7:0]                 frame_len,
   output logic                       frame_overrun,
   output logic                       erro,
   output logic [1:0]                 err_code,
   output logic [3:0]                 db_estado
);

   localparam int AW = $clog2(MAX_LEN);

   typedef enum logic [3:0] {
      OCIOSO      = 4'h0,
      COMPRIMENTO = 4'h1,
      CARGA       = 4'h2,
      CHECKSUM    = 4'h3,
      VALIDO      = 4'h4,
      ERRO        = 4'hE
   } state_t;

   state_t      state, next_state;

   logic        erro_d;
   logic        corrupt;
   logic        timed;
   logic        timeout_hit;
   logic        len_ok;
   logic [7:0]  len_q;
   logic [7:0]  csum;
   logic [7:0]  idx;
   logic [31:0] tmo_cnt;
   logic [1:0]  err_code_q;
   logic        overrun_q;
   logic [7:0]  buffer [0:MAX_LEN-1];

   logic        set_err;
   logic [1:0]  err_val;
   logic        load_len;
   logic        store_byte;

   // A parity error may precede its byte by one cycle, so look back one cycle too.
   assign corrupt     = rx_erro | erro_d;
   assign timed       = (state == COMPRIMENTO) || (state == CARGA) || (state == CHECKSUM);
   assign timeout_hit = (tmo_cnt == 32'(TIMEOUT - 1));
   assign len_ok      = (rx_dado != 8'h00) && (32'(rx_dado) <= MAX_LEN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= OCIOSO;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      set_err    = 1'b0;
      err_val    = 2'd0;
      load_len   = 1'b0;
      store_byte = 1'b0;
      case (state)
         OCIOSO: begin
            if (rx_pronto && !corrupt && (rx_dado == START_BYTE)) begin
               next_state = COMPRIMENTO;
            end
         end
         COMPRIMENTO: begin
            if (rx_pronto) begin
               if (corrupt) begin
                  set_err = 1'b1;
                  err_val = 2'd0;
               end else if (!len_ok) begin
                  set_err = 1'b1;
                  err_val = 2'd1;
               end else begin
                  load_len   = 1'b1;
                  next_state = CARGA;
               end
            end else if (timeout_hit) begin
               set_err = 1'b1;
               err_val = 2'd3;
            end
         end
         CARGA: begin
            if (rx_pronto) begin
               if (corrupt) begin
                  set_err = 1'b1;
                  err_val = 2'd0;
               end else begin
                  store_byte = 1'b1;
                  if ((idx + 8'd1) == len_q) begin
                     next_state = CHECKSUM;
                  end
               end
            end else if (timeout_hit) begin
               set_err = 1'b1;
               err_val = 2'd3;
            end
         end
         CHECKSUM: begin
            if (rx_pronto) begin
               if (corrupt) begin
                  set_err = 1'b1;
                  err_val = 2'd0;
               end else if (rx_dado != csum) begin
                  set_err = 1'b1;
                  err_val = 2'd2;
               end else begin
                  next_state = VALIDO;
               end
            end else if (timeout_hit) begin
               set_err = 1'b1;
               err_val = 2'd3;
            end
         end
         VALIDO: begin
            if (frame_ack) begin
               next_state = OCIOSO;
            end
         end
         ERRO: begin
            next_state = OCIOSO;
         end
         default: begin
            next_state = OCIOSO;
         end
      endcase
      if (set_err) begin
         next_state = ERRO;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         erro_d     <= 1'b0;
         len_q      <= 8'h00;
         csum       <= 8'h00;
         idx        <= 8'h00;
         tmo_cnt    <= 32'd0;
         err_code_q <= 2'd0;
         overrun_q  <= 1'b0;
      end else begin
         erro_d <= rx_erro;

         if (set_err) begin
            err_code_q <= err_val;
         end

         // Restart the inter-byte timer on every byte and on every state change.
         if (!timed || rx_pronto || (next_state != state)) begin
            tmo_cnt <= 32'd0;
         end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
         end

         if (state == OCIOSO) begin
            csum <= 8'h00;
            idx  <= 8'h00;
         end
         if (load_len) begin
            len_q <= rx_dado;
            csum  <= rx_dado;
         end
         if (store_byte) begin
            csum <= csum ^ rx_dado;
            idx  <= idx + 8'd1;
         end

         if (state == VALIDO) begin
            if (frame_ack) begin
               overrun_q <= 1'b0;
            end else if (rx_pronto) begin
               overrun_q <= 1'b1;
            end
         end
      end
   end

   // Payload storage is deliberately not reset; it is only meaningful while frame_valid.
   always_ff @(posedge clock) begin
      if (store_byte) begin
         buffer[idx[AW-1:0]] <= rx_dado;
      end
   end

   assign rd_data       = (32'(rd_addr) < MAX_LEN) ? buffer[rd_addr] : 8'h00;
   assign frame_valid   = (state == VALIDO);
   assign erro          = (state == ERRO);
   assign db_estado     = state;
   assign frame_len     = len_q;
   assign frame_overrun = overrun_q;
   assign err_code      = err_code_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

   localparam int MAX_LEN = 16;
   localparam int TIMEOUT = 20;

   logic       clock     = 1'b0;
   logic       reset     = 1'b0;
   logic       rx_pronto = 1'b0;
   logic       rx_erro   = 1'b0;
   logic [7:0] rx_dado   = 8'h00;
   logic [3:0] rd_addr   = 4'h0;
   logic       frame_ack = 1'b0;
   logic [7:0] rd_data;
   logic       frame_valid;
   logic [7:0] frame_len;
   logic       frame_overrun;
   logic       erro;
   logic [1:0] err_code;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;
   int erro_pulses = 0;

   // frame under test: bytes plus per-byte parity flags (before / same cycle)
   logic [7:0] fb[$];
   bit         fpb[$];
   bit         fps[$];

   // reference model results
   int         m_last;
   bit         m_ok;
   logic [1:0] m_code;
   logic [7:0] m_len;
   logic [7:0] m_pay [0:MAX_LEN-1];

   rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .START_BYTE(8'h23)) dut (
      .clock(clock), .reset(reset), .rx_pronto(rx_pronto), .rx_erro(rx_erro),
      .rx_dado(rx_dado), .rd_addr(rd_addr), .frame_ack(frame_ack), .rd_data(rd_data),
      .frame_valid(frame_valid), .frame_len(frame_len), .frame_overrun(frame_overrun),
      .erro(erro), .err_code(err_code), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (erro === 1'b1) erro_pulses <= erro_pulses + 1;

   task automatic step(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit pb, input bit ps);
      if (pb) begin rx_erro = 1'b1; step(1); rx_erro = 1'b0; end
      rx_pronto = 1'b1; rx_dado = b; rx_erro = ps;
      step(1);
      rx_pronto = 1'b0; rx_erro = 1'b0;
   endtask

   task automatic clear_flags();
      fpb.delete(); fps.delete();
      foreach (fb[i]) begin fpb.push_back(1'b0); fps.push_back(1'b0); end
   endtask

   // Walks the frame by the framing rules: where it ends and how.
   task automatic model_frame();
      logic [7:0] x;
      int L;
      m_ok = 0; m_code = 2'd0; m_len = fb[1]; L = int'(fb[1]);
      if (fpb[1] || fps[1]) begin m_last = 1; m_code = 2'd0; return; end
      if (L == 0 || L > MAX_LEN) begin m_last = 1; m_code = 2'd1; return; end
      x = fb[1];
      for (int i = 0; i < L; i++) begin
         if (fpb[2+i] || fps[2+i]) begin m_last = 2 + i; m_code = 2'd0; return; end
         m_pay[i] = fb[2+i];
         x = x ^ fb[2+i];
      end
      m_last = 2 + L;
      if (fpb[m_last] || fps[m_last]) m_code = 2'd0;
      else if (fb[m_last] != x) m_code = 2'd2;
      else m_ok = 1;
   endtask

   task automatic run_frame(input int maxgap);
      int p0;
      model_frame();
      p0 = erro_pulses;
      for (int k = 0; k <= m_last; k++) begin
         if (k > 0 && fps[k-1]) step(1);
         step($urandom_range(maxgap, 0));
         send_byte(fb[k], fpb[k], fps[k]);
      end
      if (m_ok) begin
         checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b want 1", frame_valid); end
         checks++; if (db_estado !== 4'h4) begin errors++; $display("FAIL valid_state got %h want 4", db_estado); end
         checks++; if (frame_len !== m_len) begin errors++; $display("FAIL frame_len got %h want %h", frame_len, m_len); end
         checks++; if (erro_pulses != p0 || erro !== 1'b0) begin errors++; $display("FAIL good_no_erro got %0d want %0d", erro_pulses, p0); end
         for (int i = 0; i < int'(m_len); i++) begin
            rd_addr = 4'(i); #1;
            checks++; if (rd_data !== m_pay[i]) begin errors++; $display("FAIL rd_data[%0d] got %h want %h", i, rd_data, m_pay[i]); end
         end
         frame_ack = 1'b1; step(1); frame_ack = 1'b0;
         checks++; if (frame_valid !== 1'b0 || db_estado !== 4'h0) begin errors++; $display("FAIL release got %b/%h want 0/0", frame_valid, db_estado); end
      end else begin
         checks++; if (erro !== 1'b1) begin errors++; $display("FAIL erro_pulse got %b want 1", erro); end
         checks++; if (err_code !== m_code) begin errors++; $display("FAIL err_code got %0d want %0d", err_code, m_code); end
         checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL err_valid got %b want 0", frame_valid); end
         step(1);
         checks++; if (erro !== 1'b0 || db_estado !== 4'h0) begin errors++; $display("FAIL erro_one_cycle got %b/%h want 0/0", erro, db_estado); end
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", frame_valid); end
      checks++; if (frame_len !== 8'h00) begin errors++; $display("FAIL rst_len got %h want 00", frame_len); end
      checks++; if (frame_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", frame_overrun); end
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL rst_erro got %b want 0", erro); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_code got %0d want 0", err_code); end
      checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL rst_state got %h want 0", db_estado); end
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_good_frame();
      int p0;
      fb = '{8'h23, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      clear_flags();
      p0 = erro_pulses;
      for (int k = 0; k < 5; k++) begin send_byte(fb[k], 1'b0, 1'b0); step($urandom_range(2, 0)); end
      checks++; if (frame_valid !== 1'b0 || db_estado !== 4'h3) begin errors++; $display("FAIL pre_cks got %b/%h want 0/3", frame_valid, db_estado); end
      send_byte(fb[5], 1'b0, 1'b0);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", frame_valid); end
      checks++; if (frame_len !== 8'd3) begin errors++; $display("FAIL good_len got %h want 03", frame_len); end
      rd_addr = 4'd0; #1;
      checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL good_rd0 got %h want 11", rd_data); end
      rd_addr = 4'd1; #1;
      checks++; if (rd_data !== 8'h22) begin errors++; $display("FAIL good_rd1 got %h want 22", rd_data); end
      rd_addr = 4'd2; #1;
      checks++; if (rd_data !== 8'h33) begin errors++; $display("FAIL good_rd2 got %h want 33", rd_data); end
      checks++; if (erro_pulses != p0) begin errors++; $display("FAIL good_erro got %0d want %0d", erro_pulses, p0); end
      frame_ack = 1'b1; step(1); frame_ack = 1'b0;
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_ack got %b want 0", frame_valid); end
   endtask

   task automatic test_bad_checksum();
      fb = '{8'h23, 8'h02, 8'hAA, 8'h55, 8'h00};
      clear_flags();
      run_frame(2);
      checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL cks_code got %0d want 2", err_code); end
      fb = '{8'h23, 8'h01, 8'h5A, 8'h5B};
      clear_flags();
      run_frame(0);
   endtask

   task automatic test_bad_length();
      fb = '{8'h23, 8'h00};
      clear_flags();
      run_frame(0);
      checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL len0_code got %0d want 1", err_code); end
      fb = '{8'h23, 8'h11};
      clear_flags();
      run_frame(1);
      checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL len17_code got %0d want 1", err_code); end
   endtask

   task automatic test_parity();
      int p0;
      fb = '{8'h23, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      clear_flags();
      fpb[3] = 1'b1;
      run_frame(1);
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL par_code got %0d want 0", err_code); end
      p0 = erro_pulses;
      send_byte(8'h23, 1'b0, 1'b1);
      step(1);
      checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL par_start_same got %h want 0", db_estado); end
      send_byte(8'h23, 1'b1, 1'b0);
      step(1);
      checks++; if (db_estado !== 4'h0 || erro_pulses != p0) begin errors++; $display("FAIL par_start_before got %h/%0d want 0/%0d", db_estado, erro_pulses, p0); end
   endtask

   task automatic test_timeout();
      int p0;
      send_byte(8'h23, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0, 1'b0);
      step(TIMEOUT - 1);
      checks++; if (erro !== 1'b0 || db_estado !== 4'h2) begin errors++; $display("FAIL tmo_early got %b/%h want 0/2", erro, db_estado); end
      step(1);
      checks++; if (erro !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL tmo_fire got %b/%0d want 1/3", erro, err_code); end
      step(1);
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle got %b want 0", erro); end
      p0 = erro_pulses;
      send_byte(8'h23, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0, 1'b0);
      step(TIMEOUT - 1);
      send_byte(8'h22, 1'b0, 1'b0);
      checks++; if (db_estado !== 4'h3 || erro !== 1'b0) begin errors++; $display("FAIL tmo_edge_byte got %h/%b want 3/0", db_estado, erro); end
      step(TIMEOUT - 1);
      send_byte(8'h31, 1'b0, 1'b0);
      checks++; if (frame_valid !== 1'b1 || erro_pulses != p0) begin errors++; $display("FAIL tmo_edge_frame got %b/%0d want 1/%0d", frame_valid, erro_pulses, p0); end
      rd_addr = 4'd1; #1;
      checks++; if (rd_data !== 8'h22) begin errors++; $display("FAIL tmo_edge_rd got %h want 22", rd_data); end
      frame_ack = 1'b1; step(1); frame_ack = 1'b0;
   endtask

   task automatic test_overrun();
      fb = '{8'h23, 8'h02, 8'hC3, 8'h7E, 8'hBF};
      foreach (fb[k]) send_byte(fb[k], 1'b0, 1'b0);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", frame_valid); end
      send_byte(8'h44, 1'b0, 1'b0);
      checks++; if (frame_overrun !== 1'b1 || frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_set got %b/%b want 1/1", frame_overrun, frame_valid); end
      step(2);
      checks++; if (frame_overrun !== 1'b1 || frame_len !== 8'd2) begin errors++; $display("FAIL ovr_sticky got %b/%h want 1/02", frame_overrun, frame_len); end
      rd_addr = 4'd0; #1;
      checks++; if (rd_data !== 8'hC3) begin errors++; $display("FAIL ovr_rd0 got %h want c3", rd_data); end
      rd_addr = 4'd1; #1;
      checks++; if (rd_data !== 8'h7E) begin errors++; $display("FAIL ovr_rd1 got %h want 7e", rd_data); end
      frame_ack = 1'b1; step(1); frame_ack = 1'b0;
      checks++; if (frame_overrun !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b/%b want 0/0", frame_overrun, frame_valid); end
   endtask

   task automatic test_random();
      int kind, L, pos;
      logic [7:0] x, b;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(3, 0);
         fb.delete();
         fb.push_back(8'h23);
         if (kind == 1) begin
            L = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(40, MAX_LEN + 1);
            fb.push_back(8'(L));
         end else begin
            L = $urandom_range(MAX_LEN, 1);
            fb.push_back(8'(L));
            x = 8'(L);
            for (int i = 0; i < L; i++) begin
               b = 8'($urandom);
               fb.push_back(b);
               x = x ^ b;
            end
            if (kind == 2) x = x ^ 8'($urandom_range(255, 1));
            fb.push_back(x);
         end
         clear_flags();
         if (kind == 3) begin
            pos = $urandom_range(fb.size() - 1, 1);
            if ($urandom_range(1, 0) == 0) fpb[pos] = 1'b1; else fps[pos] = 1'b1;
         end
         run_frame(3);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      fb = '{8'h23, 8'h00};
      clear_flags();
      run_frame(0);
      p0 = erro_pulses;
      send_byte(8'h23, 1'b0, 1'b0);
      send_byte(8'h04, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      checks++; if (db_estado !== 4'h2) begin errors++; $display("FAIL mid_pre got %h want 2", db_estado); end
      #2 reset = 1'b1;
      #1;
      checks++; if (db_estado !== 4'h0 || frame_valid !== 1'b0 || erro !== 1'b0) begin errors++; $display("FAIL mid_state got %h/%b/%b want 0/0/0", db_estado, frame_valid, erro); end
      checks++; if (err_code !== 2'd0 || frame_len !== 8'h00 || frame_overrun !== 1'b0) begin errors++; $display("FAIL mid_regs got %0d/%h/%b want 0/00/0", err_code, frame_len, frame_overrun); end
      step(1);
      reset = 1'b0;
      step(2);
      checks++; if (db_estado !== 4'h0 || erro_pulses != p0) begin errors++; $display("FAIL mid_after got %h/%0d want 0/%0d", db_estado, erro_pulses, p0); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_length();
      test_parity();
      test_timeout();
      test_overrun();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Frame-level controller that sits after the serial receiver (`rx_serial` datapath plus its control unit). It consumes the receiver's per-byte completion pulses and sequences the incoming bytes into a framed packet of the form start byte, length byte, payload, checksum. It validates each frame, stores the payload in an internal buffer, and presents it to the consumer through a read port with a valid/ack handshake. Parity errors, bad length, checksum mismatch and inter-byte timeout are reported through one error pulse and an error code.

## Interface
- `MAX_LEN`, default 16: maximum payload bytes; buffer depth.
- `TIMEOUT`, default 50000: inter-byte timeout in clock cycles.
- `START_BYTE`, default 8'h23: frame start marker.
- `clock` in, 1: system clock, rising edge.
- `reset` in, 1: asynchronous, active-high.
- `rx_pronto` in, 1: one-cycle pulse from the receiver; `rx_dado` is valid in that cycle.
- `rx_erro` in, 1: receiver parity-error pulse; occurs in the same cycle as `rx_pronto` or one cycle before it.
- `rx_dado` in, 8: received byte.
- `rd_addr` in, $clog2(MAX_LEN): payload read address.
- `frame_ack` in, 1: consumer releases the buffer.
- `rd_data` out, 8: payload byte at `rd_addr`.
- `frame_valid` out, 1: a complete, verified frame is held.
- `frame_len` out, 8: payload length of the held frame.
- `frame_overrun` out, 1: sticky; a byte arrived while a frame was held.
- `erro` out, 1: one-cycle frame error pulse.
- `err_code` out, 2: cause of the last error.
- `db_estado` out, 4: debug state encoding.

## Operation
- States and their `db_estado` encodings: OCIOSO 0x0, COMPRIMENTO 0x1, CARGA 0x2, CHECKSUM 0x3, VALIDO 0x4, ERRO 0xE.
- **Byte corruption:** a byte is corrupt if `rx_erro` is high in the `rx_pronto` cycle or in the cycle before it. Track this with a one-cycle delayed `rx_erro` register.
- **OCIOSO:**
  - On `rx_pronto` with an uncorrupted `rx_dado == START_BYTE`, go to COMPRIMENTO.
  - Clear the checksum accumulator and the byte index.
  - Ignore any other byte silently.
- **COMPRIMENTO:**
  - On `rx_pronto`, if the byte is corrupt, go to ERRO with code 0.
  - If the length is 0 or greater than `MAX_LEN`, go to ERRO with code 1.
  - Otherwise latch the length, set checksum = length, and go to CARGA.
- **CARGA:**
  - On `rx_pronto`, a corrupt byte sends the FSM to ERRO with code 0.
  - Otherwise write `buffer[idx] = rx_dado`, XOR the byte into the checksum, and increment `idx`.
  - When `idx` reaches length, go to CHECKSUM.
- **CHECKSUM:**
  - On `rx_pronto`, a corrupt byte gives code 0.
  - A byte that differs from the accumulated XOR gives code 2.
  - A matching byte goes to VALIDO.
- **Timeout:**
  - In COMPRIMENTO, CARGA and CHECKSUM, a counter clears on entry and on every `rx_pronto`.
  - If it reaches `TIMEOUT-1` with no `rx_pronto`, go to ERRO with code 3.
  - If `rx_pronto` arrives in the same cycle as the timeout, the byte wins.
- **VALIDO:**
  - `frame_valid` = 1.
  - The buffer and `frame_len` are frozen.
  - Any `rx_pronto` sets `frame_overrun`; the byte is dropped.
  - `frame_ack` returns the FSM to OCIOSO and clears `frame_overrun`.
- **ERRO:** lasts one cycle with `erro` = 1, then goes to OCIOSO. `err_code` is registered on entry to ERRO and held until the next error.
- **Read port:**
  - `rd_data` = `buffer[rd_addr]`, combinational read.
  - Addresses at or beyond `MAX_LEN` return 0x00.
  - Contents are meaningful only while `frame_valid` = 1.
- **Width rules:** the checksum is an 8-bit XOR, with no carry. `idx` is an 8-bit counter.

## Timing
- **Reset values:** the state goes to OCIOSO; `frame_valid`, `frame_len`, `frame_overrun`, `erro`, `err_code` and `db_estado` are all 0. Buffer contents are not reset.
- **Registered outputs:** the state register drives `frame_valid`, `erro` and `db_estado` through Moore decoding, so they are glitch-free.
- **Latency:** `frame_valid` rises on the edge after the clock that samples the checksum byte's `rx_pronto`.
- **Error latency:** `erro` rises one cycle after the offending `rx_pronto` or timeout, and is high for exactly one cycle.
- **Release:** `frame_valid` falls on the edge after `frame_ack` is sampled high. `frame_ack` outside VALIDO is ignored.
- **Back-to-back frames:** the FSM accepts a start byte in the very next cycle after returning to OCIOSO.
- **Reset mid-frame:** an asynchronous abort to OCIOSO with no `erro` pulse.

## Test plan
- **Good frame:** bytes 23 03 11 22 33 03 → `frame_valid` = 1, `frame_len` = 3, `rd_addr` 0/1/2 reads 11/22/33, `erro` never asserted. Then `frame_ack` → `frame_valid` = 0 the next cycle.
- **Bad checksum:** 23 02 AA 55 00 → one-cycle `erro`, `err_code` = 2, `frame_valid` stays 0. A following good frame is accepted.
- **Bad length:** 23 00, then separately 23 11 with `MAX_LEN` = 16 → `erro` with `err_code` = 1 each time.
- **Parity error:** `rx_erro` pulsed one cycle before the 2nd payload byte's `rx_pronto` → `err_code` = 0. A byte 23 with `rx_erro` in OCIOSO is ignored and the FSM stays in OCIOSO.
- **Timeout:** 23 02 11, then silence for `TIMEOUT` cycles (set to 20) → `erro` with `err_code` = 3.
  - A byte arriving exactly at cycle 19 is accepted with no error.
- **Overrun and reset:**
  - With a frame held, send byte 44 → `frame_overrun` = 1, buffer unchanged. `frame_ack` clears it.
  - Asserting `reset` mid-CARGA → all outputs 0 and `db_estado` = 0x0.
